// File: rtl/add_32_arbiter_if.sv
// add_32_arbiter_if: request/response bundle between two adder clients and the shared-adder arbiter
// req0_*/req1_*: valid/ready request channels carrying a, b and sub (1 = a-b)
// rsp_*: valid/ready response channel carrying id, sum, cout (not-borrow on sub), ovf, zero
interface add_32_arbiter_if;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, rsp_zero;
  logic [31:0] rsp_sum;
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero
  );
endinterface

// File: rtl/add_32_arbiter.sv
// add_32_arbiter: round-robin sharing of one add_32 between two requesters, with two-pass subtraction
// clk, reset (async, active-high); bus: add_32_arbiter_if.slave (request channels in, response channel out)
module add_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        c_out,
  output logic        overflow,
  output logic        zero_flag
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b};
  assign overflow   = (a[31] == b[31]) & (s[31] != a[31]);
  assign zero_flag  = s == '0;
endmodule

module add_32_arbiter (
  input  logic             clk,
  input  logic             reset,
  add_32_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d, id_q, id_d, sub_q, sub_d, c1_q, c1_d;
  logic [31:0] a_q, a_d, b_q, b_d, t_q, t_d, sum_q, sum_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic        cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic        gnt, idle;
  logic [31:0] add_a, add_b, s;
  logic        c_out, overflow, zero_flag;
  add_32 u_add (
    .a(add_a), .b(add_b), .s(s), .c_out(c_out), .overflow(overflow), .zero_flag(zero_flag)
  );
  // grant: the lone valid requester, or the one opposite last_grant under contention
  assign gnt            = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign idle           = ~reset & (state_q == IDLE);
  assign bus.req0_ready = idle & bus.req0_valid & ~gnt;
  assign bus.req1_ready = idle & bus.req1_valid & gnt;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.rsp_zero   = zero_q;
  // subtraction is a + ~b in PASS1, then t + 1 in PASS2; idle states park the adder at zero
  assign add_a = state_q == PASS1 ? a_q : state_q == PASS2 ? t_q : '0;
  assign add_b = state_q == PASS1 ? (sub_q ? ~b_q : b_q) : state_q == PASS2 ? 32'd1 : '0;
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    sub_d        = sub_q;
    a_d          = a_q;
    b_d          = b_q;
    t_d          = t_q;
    c1_d         = c1_q;
    rsp_id_d     = rsp_id_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: if (bus.req0_ready | bus.req1_ready) begin
        state_d      = PASS1;
        a_d          = gnt ? bus.req1_a : bus.req0_a;
        b_d          = gnt ? bus.req1_b : bus.req0_b;
        sub_d        = gnt ? bus.req1_sub : bus.req0_sub;
        id_d         = gnt;
        last_grant_d = gnt;
      end
      PASS1: begin
        t_d     = s;
        c1_d    = c_out;
        state_d = sub_q ? PASS2 : RESP;
        if (!sub_q) begin
          sum_d    = s;
          cout_d   = c_out;
          ovf_d    = overflow;
          zero_d   = zero_flag;
          rsp_id_d = id_q;
        end
      end
      PASS2: begin
        state_d  = RESP;
        sum_d    = s;
        zero_d   = zero_flag;
        // at most one of the two passes can carry; either one means no borrow
        cout_d   = c1_q | c_out;
        // adder's own overflow would judge t+1, so derive it from the original operands
        ovf_d    = (a_q[31] != b_q[31]) & (s[31] != a_q[31]);
        rsp_id_d = id_q;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    rsp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      sub_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      t_q          <= '0;
      c1_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      sub_q        <= sub_d;
      a_q          <= a_d;
      b_q          <= b_d;
      t_q          <= t_d;
      c1_q         <= c1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
    end
  end
endmodule

// File: tb/tb_add_32_arbiter.sv
// tb_add_32_arbiter: directed and randomized checks of add_32_arbiter against an arithmetic reference model
module tb_add_32_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  add_32_arbiter_if bus();
  add_32_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {cout, ovf, zero, sum} from plain wide arithmetic
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] w;
    longint      r;
    logic        c, o;
    if (sub) begin
      w = {1'b0, a} - {1'b0, b};
      c = a >= b;
      r = longint'(int'(a)) - longint'(int'(b));
    end else begin
      w = {1'b0, a} + {1'b0, b};
      c = w[32];
      r = longint'(int'(a)) + longint'(int'(b));
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {c, o, w[31:0] == 32'd0, w[31:0]};
  endfunction

  function automatic logic [35:0] rsp();
    return {bus.rsp_id, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero, bus.rsp_sum};
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic run_op(input string tag, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, input logic [35:0] exp);
    int lat;
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
    end
    #1;
    chk({tag, "_rdy"}, {bus.req1_ready, bus.req0_ready}, id ? 2'b10 : 2'b01);
    cyc();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req1_a = $urandom; bus.req1_b = $urandom;
    bus.req0_sub = ~sub; bus.req1_sub = ~sub;
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin
      cyc();
      lat++;
    end
    chk({tag, "_lat"}, lat, sub ? 2 : 1);
    chk({tag, "_rsp"}, rsp(), exp);
    bus.rsp_ready = 1'b1;
    cyc();
    chk({tag, "_drop"}, bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [35:0] exp, snap;
    logic        v0, v1, g, acc0, acc1;
    int          phase, cnt, w, bad;
    bit          last;
    logic [0:0]  got[$];
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.req0_sub = 0; bus.req1_sub = 0; bus.rsp_ready = 0;
    #2;
    chk("rst_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
    chk("rst_rsp", {bus.rsp_valid, rsp()}, 37'h0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    do_reset();
    // contention straight out of reset: grants and responses alternate 0,1,0,1
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req1_a = $urandom; bus.req1_b = $urandom;
    bus.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(bus.req0_ready | bus.req1_ready) && w < 10) begin
        if (bus.rsp_valid) got.push_back(bus.rsp_id);
        cyc();
        w++;
      end
      chk("cont_gnt", {bus.req1_ready, bus.req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      cyc();
      chk("cont_pulse", {bus.req1_ready, bus.req0_ready}, 2'b00);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    w = 0;
    while (got.size() < 4 && w < 10) begin
      if (bus.rsp_valid) got.push_back(bus.rsp_id);
      cyc();
      w++;
    end
    chk("cont_n", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("cont_id", got[i], i % 2);
    bus.rsp_ready = 1'b0;
    cyc();
    // directed arithmetic corners, expected as {id, cout, ovf, zero, sum}
    run_op("add_ovf",  1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, {4'b0010, 32'h80000000});
    run_op("sub_eq",   1'b1, 32'd5,        32'd5, 1'b1, {4'b1101, 32'h0});
    run_op("sub_ovf",  1'b0, 32'h80000000, 32'h1, 1'b1, {4'b0110, 32'h7FFFFFFF});
    run_op("sub_brw",  1'b1, 32'h0,        32'h1, 1'b1, {4'b1000, 32'hFFFFFFFF});
    run_op("add_wrap", 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, {4'b0101, 32'h0});
    // backpressure: response held stable, no grants while waiting
    run_op("pre_bp", 1'b1, 32'd1, 32'd1, 1'b0, {4'b1000, 32'd2});
    bus.req0_a = 32'd10; bus.req0_b = 32'd3; bus.req0_sub = 1'b1; bus.req0_valid = 1'b1;
    #1;
    chk("bp_rdy", {bus.req1_ready, bus.req0_ready}, 2'b01);
    cyc();
    bus.req0_valid = 1'b0;
    w = 0;
    while (!bus.rsp_valid && w < 10) begin
      cyc();
      w++;
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_vld", bus.rsp_valid, 1'b1);
      chk("bp_rsp", rsp(), {4'b0100, 32'd7});
      chk("bp_rdy_low", {bus.req1_ready, bus.req0_ready}, 2'b00);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("bp_drop", bus.rsp_valid, 1'b0);
    chk("bp_next_gnt", {bus.req1_ready, bus.req0_ready}, 2'b10);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    // reset while a subtraction sits in PASS2
    bus.req1_a = 32'd9; bus.req1_b = 32'd4; bus.req1_sub = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("rm_rdy", {bus.req1_ready, bus.req0_ready}, 2'b10);
    cyc();
    bus.req1_valid = 1'b0;
    cyc();
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    #1;
    chk("rm_rdy_rst", {bus.req1_ready, bus.req0_ready}, 2'b00);
    chk("rm_vld_rst", bus.rsp_valid, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rm_last_gnt", {bus.req1_ready, bus.req0_ready}, 2'b01);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (bus.rsp_valid !== 1'b0) bad++;
    end
    chk("rm_no_rsp", bad, 0);
    run_op("rm_after", 1'b1, 32'd9, 32'd4, 1'b1, {4'b1100, 32'd5});
    // randomized traffic against the reference model
    do_reset();
    phase = 0; cnt = 0; last = 1'b1; exp = '0; acc0 = 1'b1; acc1 = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (acc0 || !bus.req0_valid) begin
        bus.req0_valid = $urandom % 2; bus.req0_a = rop(); bus.req0_b = rop(); bus.req0_sub = $urandom % 2;
      end
      if (acc1 || !bus.req1_valid) begin
        bus.req1_valid = $urandom % 2; bus.req1_a = rop(); bus.req1_b = rop(); bus.req1_sub = $urandom % 2;
      end
      bus.rsp_ready = ($urandom % 3) != 0;
      #1;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      g = (v0 && v1) ? !last : v1;
      chk("rnd_rdy", {bus.req1_ready, bus.req0_ready}, (phase == 0) ? {v1 & g, v0 & ~g} : 2'b00);
      chk("rnd_vld", bus.rsp_valid, phase == 2);
      if (phase == 2) chk("rnd_rsp", rsp(), exp);
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (phase == 0 && (v0 || v1)) begin
        exp = {g, model(g ? bus.req1_a : bus.req0_a, g ? bus.req1_b : bus.req0_b, g ? bus.req1_sub : bus.req0_sub)};
        cnt = (g ? bus.req1_sub : bus.req0_sub) ? 2 : 1;
        last = g;
        phase = 1;
        acc0 = ~g;
        acc1 = g;
      end else if (phase == 1) begin
        cnt--;
        if (cnt == 0) phase = 2;
      end else if (phase == 2 && bus.rsp_ready) begin
        phase = 0;
      end
      @(posedge clk);
      #1;
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
